sd_cmd_engine: RTL
==================

SD_CMD_ENGINE -- requirements
Module: sd_cmd_engine

Interface
REQ-001 Parameters SHALL be: NCR_MAX, default 64, cycles waited for response start bit before timeout; NCC_MIN, default 8, idle cycles enforced after each command completes.
REQ-002 Ports SHALL be:
- CLK_SD_card  in  1  SD card clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- new_cmd  in  1  single-cycle request to start a command.
- cmd_index  in  6  command index.
- cmd_arg  in  32  command argument.
- resp_type  in  2  response type: 00 none; 01 48-bit with CRC; 10 136-bit (R2); 11 48-bit, no CRC check (R3).
- cmd_from_sd  in  1  serial CMD line from the card.
- cmd_to_sd  out  1  serial CMD line to the card.
- cmd_to_sd_oe  out  1  output enable for the CMD line.
- cmd_busy  out  1  engine is occupied.
- cmd_complete  out  1  one-cycle completion pulse.
- timeout_error  out  1  sticky: no response start bit was seen.
- crc_error  out  1  sticky: response CRC7 mismatch.
- end_bit_error  out  1  sticky: response end bit was 0.
- resp_index  out  6  response bits [45:40] (48-bit types).
- response  out  128  48-bit types: status bits [39:8] in response[31:0], upper bits 0; R2: frame bits [127:0].

Function
REQ-003 The engine SHALL be a state machine with states IDLE, SEND, TURN, WAIT_START, RECV, CHECK and GAP.
REQ-004 In IDLE, new_cmd=1 SHALL latch cmd_index, cmd_arg and resp_type, clear all three error flags, and move to SEND on the next edge.
REQ-005 new_cmd SHALL be ignored in every state other than IDLE.
REQ-006 SEND SHALL last exactly 48 cycles and shift out the frame MSB-first with cmd_to_sd_oe=1. Frame order: start bit 0, transmission bit 1, index[5:0], arg[31:0], CRC7[6:0], end bit 1.
REQ-007 CRC7 SHALL use polynomial x^7+x^3+1 with a zero seed, computed over the first 40 frame bits serially during SEND.
REQ-008 Whenever cmd_to_sd_oe=0, cmd_to_sd SHALL be 1.
REQ-009 After SEND: resp_type 00 SHALL go directly to GAP; any other type SHALL go to TURN.
REQ-010 TURN SHALL last 2 cycles with oe=0, then go to WAIT_START.
REQ-011 WAIT_START SHALL count cycles. cmd_from_sd=0 SHALL go to RECV with that bit taken as frame bit 47 (or 135 for R2).
REQ-012 If NCR_MAX cycles elapse with no start bit, the engine SHALL set timeout_error and go to GAP.
REQ-013 RECV SHALL sample the remaining 47 bits (48-bit types) or 135 bits (R2), one per cycle, then go to CHECK.
REQ-014 CHECK SHALL last one cycle and SHALL set end_bit_error if the last bit sampled was 0.
REQ-015 In CHECK, CRC7 SHALL be computed over frame bits [47:8] for 01, or over bits [127:8] for 10, and compared with bits [7:1]; a mismatch SHALL set crc_error. Type 11 SHALL never set crc_error.
REQ-016 CHECK SHALL update response and resp_index, then go to GAP.
REQ-017 cmd_complete SHALL pulse for exactly 1 cycle on entry to GAP, including on timeout.
REQ-018 GAP SHALL hold oe=0 for NCC_MIN cycles, then return to IDLE.
REQ-019 cmd_busy SHALL be 1 in every state except IDLE.
REQ-020 Error flags and response SHALL hold their values until the next accepted new_cmd.

Reset
REQ-021 reset=0 SHALL take effect immediately, in any state including mid-frame, and SHALL force:
- state IDLE;
- cmd_to_sd=1, cmd_to_sd_oe=0;
- cmd_busy=0, cmd_complete=0;
- all error flags 0;
- response=0, resp_index=0;
- all counters 0.

Configuration
REQ-022 With CMD_CRC7_CHECK_EN defined, response CRC7 checking SHALL operate per REQ-015.
REQ-023 Without CMD_CRC7_CHECK_EN, no receive CRC logic SHALL be built and crc_error SHALL be tied to 0. Transmit CRC is always present.

Verification
REQ-024 CMD0, arg 0x00000000, type 00 -> line carries 0x400000000095; cmd_complete 1 cycle after the last bit; busy clears after 8 GAP cycles.
REQ-025 CMD8, arg 0x000001AA, type 01; card returns 0x08000001AA13 -> frame 0x48000001AA87 sent; resp_index=8, response[31:0]=0x000001AA, no errors.
REQ-026 CMD17, arg 0, type 01; card silent -> frame 0x510000000055; timeout_error=1 after 64 WAIT_START cycles; complete pulses.
REQ-027 Type 01 response with one flipped CRC bit -> crc_error=1 with macro defined, crc_error=0 without it. Same response with end bit 0 -> end_bit_error=1.
REQ-028 R2 response, then new_cmd pulsed during RECV and reset asserted mid-RECV -> extra new_cmd ignored; on reset, oe=0, busy=0 and response=0 immediately.

Source files
------------

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: serialises 48-bit commands with CRC7 and captures 48-bit or 136-bit responses.
// Optional feature macro CMD_CRC7_CHECK_EN builds receive-side CRC7 checking; without it crc_error is tied to 0.
module sd_cmd_engine #(
    parameter int NCR_MAX = 64,
    parameter int NCC_MIN = 8
) (
    input  logic         CLK_SD_card,
    input  logic         reset,
    input  logic         new_cmd,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    input  logic         cmd_from_sd,
    output logic         cmd_to_sd,
    output logic         cmd_to_sd_oe,
    output logic         cmd_busy,
    output logic         cmd_complete,
    output logic         timeout_error,
    output logic         crc_error,
    output logic         end_bit_error,
    output logic [5:0]   resp_index,
    output logic [127:0] response
);
    localparam int CW = 16;

    typedef enum logic [2:0] {
        IDLE, SEND, TURN, WAIT_START, RECV, CHECK, GAP
    } state_t;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    state_t         state_q, state_d;
    logic [46:0]    tx_q, tx_d;
    logic [6:0]     crc_q, crc_d;
    logic [1:0]     rtype_q, rtype_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [127:0]   rx_q, rx_d;
    logic           cmd_to_sd_q, cmd_to_sd_d;
    logic           oe_q, oe_d;
    logic           busy_q, busy_d;
    logic           complete_q, complete_d;
    logic           to_err_q, to_err_d;
    logic           end_err_q, end_err_d;
    logic [5:0]     resp_index_q, resp_index_d;
    logic [127:0]   response_q, response_d;

    // Next-state and datapath for the command/response sequence
    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        crc_d        = crc_q;
        rtype_d      = rtype_q;
        cnt_d        = cnt_q;
        rx_d         = rx_q;
        cmd_to_sd_d  = cmd_to_sd_q;
        oe_d         = oe_q;
        complete_d   = 1'b0;
        to_err_d     = to_err_q;
        end_err_d    = end_err_q;
        resp_index_d = resp_index_q;
        response_d   = response_q;
        case (state_q)
            IDLE: begin
                if (new_cmd) begin
                    // start bit goes out now; tx_q holds the remaining 47 bits with CRC slots zeroed
                    state_d     = SEND;
                    tx_d        = {1'b1, cmd_index, cmd_arg, 7'h00, 1'b1};
                    rtype_d     = resp_type;
                    crc_d       = crc7_step(7'h00, 1'b0);
                    cmd_to_sd_d = 1'b0;
                    oe_d        = 1'b1;
                    cnt_d       = {CW{1'b0}};
                    to_err_d    = 1'b0;
                    end_err_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (cnt_q == 16'd47) begin
                    oe_d        = 1'b0;
                    cmd_to_sd_d = 1'b1;
                    cnt_d       = {CW{1'b0}};
                    if (rtype_q == 2'b00) begin
                        state_d    = GAP;
                        complete_d = 1'b1;
                    end else begin
                        state_d = TURN;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    tx_d  = {tx_q[45:0], 1'b0};
                    // frame bits 40..46 come from the running CRC rather than the shifter
                    if ((cnt_q >= 16'd39) && (cnt_q <= 16'd45)) begin
                        cmd_to_sd_d = crc_q[6];
                        crc_d       = {crc_q[5:0], 1'b0};
                    end else begin
                        cmd_to_sd_d = tx_q[46];
                        crc_d       = crc7_step(crc_q, tx_q[46]);
                    end
                end
            end
            TURN: begin
                if (cnt_q == 16'd1) begin
                    state_d = WAIT_START;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_START: begin
                if (!cmd_from_sd) begin
                    state_d = RECV;
                    rx_d    = 128'd0;
                    cnt_d   = {CW{1'b0}};
                end else if (cnt_q == CW'(NCR_MAX - 1)) begin
                    state_d    = GAP;
                    to_err_d   = 1'b1;
                    complete_d = 1'b1;
                    cnt_d      = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RECV: begin
                rx_d = {rx_q[126:0], cmd_from_sd};
                if (cnt_q == ((rtype_q == 2'b10) ? 16'd134 : 16'd46)) begin
                    state_d = CHECK;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            CHECK: begin
                end_err_d = ~rx_q[0];
                if (rtype_q == 2'b10) begin
                    response_d   = rx_q;
                    resp_index_d = 6'd0;
                end else begin
                    response_d   = {96'd0, rx_q[39:8]};
                    resp_index_d = rx_q[45:40];
                end
                state_d    = GAP;
                complete_d = 1'b1;
                cnt_d      = {CW{1'b0}};
            end
            GAP: begin
                if (cnt_q == CW'(NCC_MIN - 1)) begin
                    state_d = IDLE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge CLK_SD_card or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            tx_q         <= 47'd0;
            crc_q        <= 7'd0;
            rtype_q      <= 2'd0;
            cnt_q        <= {CW{1'b0}};
            rx_q         <= 128'd0;
            cmd_to_sd_q  <= 1'b1;
            oe_q         <= 1'b0;
            busy_q       <= 1'b0;
            complete_q   <= 1'b0;
            to_err_q     <= 1'b0;
            end_err_q    <= 1'b0;
            resp_index_q <= 6'd0;
            response_q   <= 128'd0;
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            crc_q        <= crc_d;
            rtype_q      <= rtype_d;
            cnt_q        <= cnt_d;
            rx_q         <= rx_d;
            cmd_to_sd_q  <= cmd_to_sd_d;
            oe_q         <= oe_d;
            busy_q       <= busy_d;
            complete_q   <= complete_d;
            to_err_q     <= to_err_d;
            end_err_q    <= end_err_d;
            resp_index_q <= resp_index_d;
            response_q   <= response_d;
        end
    end

`ifdef CMD_CRC7_CHECK_EN
    function automatic logic [6:0] crc7_rx(input logic [127:0] frame, input logic is_r2);
        logic [6:0] crc;
        crc = 7'h00;
        for (int i = 127; i >= 8; i--) begin
            if (is_r2 || (i <= 47)) begin
                crc = crc7_step(crc, frame[i]);
            end else begin
                crc = crc;
            end
        end
        return crc;
    endfunction

    logic crc_err_q, crc_err_d;

    // Receive CRC verdict; R3 (type 11) is never checked
    always_comb begin
        crc_err_d = crc_err_q;
        if ((state_q == IDLE) && new_cmd) begin
            crc_err_d = 1'b0;
        end else if ((state_q == CHECK) && ((rtype_q == 2'b01) || (rtype_q == 2'b10))) begin
            crc_err_d = (crc7_rx(rx_q, rtype_q == 2'b10) != rx_q[7:1]);
        end else begin
            crc_err_d = crc_err_q;
        end
    end

    // Sticky CRC error register
    always_ff @(posedge CLK_SD_card or negedge reset) begin
        if (!reset) begin
            crc_err_q <= 1'b0;
        end else begin
            crc_err_q <= crc_err_d;
        end
    end

    assign crc_error = crc_err_q;
`else
    logic unused_rx_crc_s;
    assign unused_rx_crc_s = ^rx_q[7:1];
    assign crc_error       = 1'b0;
`endif

    assign cmd_to_sd     = cmd_to_sd_q;
    assign cmd_to_sd_oe  = oe_q;
    assign cmd_busy      = busy_q;
    assign cmd_complete  = complete_q;
    assign timeout_error = to_err_q;
    assign end_bit_error = end_err_q;
    assign resp_index    = resp_index_q;
    assign response      = response_q;
endmodule
